// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Types and constants shared by the 8-deep byte FIFO and its
//               read-side burst controller.
//               DEF_DATA_WIDTH - default FIFO/stream word width
//               rd_state_t     - burst reader FSM states (IDLE/RUN/FLUSH)
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } rd_state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_burst_reader_skid.sv
`default_nettype none
// ============================================================================
// Module      : skid_buf2
// Description : Two-entry register FIFO that absorbs the read latency of the
//               upstream FIFO. The head entry drives dout directly from a
//               flop, so dout is held while the entry is not popped.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write din at the tail
//   pop        : remove the head entry (ignored when empty)
//   dout       : head entry
//   count      : occupancy, 0..2
// Revision    : 1.0 - initial release
// ============================================================================
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic [1:0]            r_count;
    logic                  w_pop;
    logic                  w_push;

    assign w_pop  = pop && (r_count != 2'd0);
    // A push into a full buffer is only legal when the head leaves in the
    // same cycle; otherwise it is dropped rather than corrupting the tail.
    assign w_push = push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= din;
                    else                 r_tail <= din;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= din;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout  = r_head;
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : fifo_burst_reader
// Description : On a start pulse, pops exactly burst_len words from the input
//               FIFO and streams them out on a valid/ready interface at up to
//               one word per cycle.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, burst_len     : burst request (sampled in IDLE only)
//   busy, done           : burst in progress / one-cycle completion pulse
//   fifo_rden            : FIFO pop request
//   fifo_rdata           : FIFO data, valid the cycle after fifo_rden
//   fifo_empty           : FIFO empty flag
//   m_valid, m_data      : output stream
//   m_ready              : downstream accept
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_W-1:0]      burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_rden,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready
);

    localparam logic [LEN_W-1:0] c_LEN_ONE = LEN_W'(1);

    rd_state_t        r_state;
    rd_state_t        w_next_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_issued;
    logic [LEN_W-1:0] r_accepted;
    logic [LEN_W-1:0] w_issued_inc;
    logic [LEN_W-1:0] w_accepted_inc;
    logic             r_inflight;
    logic             r_busy;
    logic             r_done;
    logic             w_done_next;
    logic             w_rden;
    logic             w_hs;
    logic             w_credit;
    logic [1:0]       w_occ;
    logic [1:0]       w_fill;

    assign w_hs           = m_valid && m_ready;
    assign w_issued_inc   = r_issued + c_LEN_ONE;
    assign w_accepted_inc = r_accepted + c_LEN_ONE;

    // Words already committed to the skid buffer: stored plus the one whose
    // data arrives next cycle. A handshake this cycle frees one slot.
    assign w_fill   = w_occ + {1'b0, r_inflight};
    assign w_credit = (w_fill < 2'd2) || w_hs;

    always_comb begin
        w_next_state = r_state;
        w_rden       = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (burst_len == '0) w_done_next  = 1'b1;
                    else                 w_next_state = RUN;
                end
            end
            RUN: begin
                w_rden = !fifo_empty && (r_issued < r_len) && w_credit;
                if (w_rden && (w_issued_inc == r_len)) w_next_state = FLUSH;
            end
            FLUSH: begin
                // The final handshake always lands here: the last word needs
                // at least two cycles after its pop to reach the output.
                if (w_hs && (w_accepted_inc == r_len)) begin
                    w_next_state = IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_issued   <= '0;
            r_accepted <= '0;
            r_inflight <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_inflight <= w_rden;
            r_busy     <= (w_next_state != IDLE);
            r_done     <= w_done_next;
            if (r_state == IDLE) begin
                if (start) begin
                    r_len      <= burst_len;
                    r_issued   <= '0;
                    r_accepted <= '0;
                end
            end else begin
                if (w_rden) r_issued   <= w_issued_inc;
                if (w_hs)   r_accepted <= w_accepted_inc;
            end
        end
    end

    skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (r_inflight),
        .din   (fifo_rdata),
        .pop   (w_hs),
        .dout  (m_data),
        .count (w_occ)
    );

    assign m_valid   = (w_occ != 2'd0);
    assign fifo_rden = w_rden;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fifo_burst_reader
// Description : Self-checking bench for fifo_burst_reader. A behavioural
//               FIFO feeds the DUT; every word written is queued as the
//               expected stream, and a monitor compares each accepted beat
//               in order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [LW-1:0] burst_len;
    logic          busy;
    logic          done;
    logic          fifo_rden;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_empty;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_ready;

    always #5 clk = ~clk;

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .burst_len  (burst_len),
        .busy       (busy),
        .done       (done),
        .fifo_rden  (fifo_rden),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural FIFO: one-cycle read latency --------------
    logic [DW-1:0] mem [0:1023];
    int            wr_cnt = 0;
    int            rd_cnt = 0;
    logic          rden_s = 1'b0;

    assign fifo_empty = (wr_cnt == rd_cnt);

    always @(negedge clk) rden_s <= fifo_rden;
    always @(posedge clk) begin
        if (rden_s) begin
            fifo_rdata <= mem[rd_cnt];
            rd_cnt     <= rd_cnt + 1;
        end
    end

    // ---------------- scoreboard ---------------------------------------------
    logic [DW-1:0] exp_q [$];
    int            mon_idx   = 0;
    int            burst_acc = 0;
    int            cur_len   = 0;
    int            done_cnt  = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            // Words popped but not yet accepted are lost on reset.
            mon_idx    = rd_cnt;
            burst_acc  = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", m_valid, 1);
                check("stall_data_held", m_data, prev_data);
            end
            if (fifo_rden) begin
                check("pop_while_empty", fifo_empty, 0);
                check("outstanding_le_2",
                      (rd_cnt - mon_idx + 1 - int'(m_valid && m_ready)) <= 2, 1);
            end
            if (m_valid && m_ready) begin
                if (mon_idx < exp_q.size()) begin
                    check("stream_data", m_data, exp_q[mon_idx]);
                end else begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_beat: got %0h expected no beat", m_data);
                end
                mon_idx++;
                burst_acc++;
            end
            if (done) begin
                check("words_per_burst", burst_acc, cur_len);
                check("busy_low_at_done", busy, 0);
                done_cnt++;
                burst_acc = 0;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    // ---------------- m_ready driver -----------------------------------------
    int rmode = 0;
    int rph   = 0;
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rph++;
            case (rmode)
                1:       m_ready = (rph % 3 == 0);
                2:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b1;
            endcase
        end
    end

    // ---------------- stimulus -----------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [DW-1:0] d);
        mem[wr_cnt] = d;
        exp_q.push_back(d);
        wr_cnt++;
    endtask

    task automatic go(input int len);
        cur_len   = len;
        burst_len = LW'(len);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        check({name, "_done_seen"}, seen, 1);
        tick();
    endtask

    initial begin
        int d0;
        int rc;
        int len;
        rst_n     = 1'b0;
        start     = 1'b0;
        burst_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rden", fifo_rden, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // single word, latency
        write_word(8'h68);
        tick();
        go(1);
        @(negedge clk);
        check("t1_busy", busy, 1);
        check("t1_rden", fifo_rden, 1);
        @(negedge clk);
        check("t1_valid_not_yet", m_valid, 0);
        @(negedge clk);
        check("t1_valid", m_valid, 1);
        check("t1_data", m_data, 8'h68);
        @(negedge clk);
        check("t1_done", done, 1);
        check("t1_busy_low", busy, 0);
        check("t1_fifo_empty", fifo_empty, 1);
        tick();

        // three back-to-back pops
        write_word(8'h45);
        write_word(8'h35);
        write_word(8'h25);
        tick();
        go(3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2_rden_consecutive", fifo_rden, 1);
        end
        @(negedge clk);
        check("t2_rden_stop", fifo_rden, 0);
        wait_done("t2", 20);

        // full FIFO with 1,0,0 backpressure
        rmode = 1;
        for (int i = 0; i < 8; i++) write_word(DW'(i));
        tick();
        go(8);
        wait_done("t3", 200);
        rmode = 0;

        // FIFO runs dry mid-burst
        d0 = done_cnt;
        write_word(8'hA0);
        write_word(8'hA1);
        go(4);
        repeat (5) tick();
        @(negedge clk);
        check("t4_stall_rden", fifo_rden, 0);
        check("t4_stall_busy", busy, 1);
        tick();
        write_word(8'hA2);
        write_word(8'hA3);
        wait_done("t4", 50);
        repeat (3) tick();
        check("t4_done_once", done_cnt, d0 + 1);

        // zero-length burst
        d0 = done_cnt;
        go(0);
        @(negedge clk);
        check("t5_zero_done", done, 1);
        check("t5_zero_busy", busy, 0);
        check("t5_zero_rden", fifo_rden, 0);
        @(negedge clk);
        check("t5_zero_done_pulse", done, 0);
        check("t5_zero_busy2", busy, 0);
        tick();
        check("t5_zero_done_cnt", done_cnt, d0 + 1);

        // start while busy is ignored
        for (int i = 0; i < 5; i++) write_word(DW'(8'hB0 + i));
        go(2);
        start     = 1'b1;
        burst_len = LW'(3);
        tick();
        start     = 1'b0;
        wait_done("t5_busy", 50);
        repeat (4) tick();
        check("t5_ignored_left", wr_cnt - rd_cnt, 3);
        check("t5_ignored_idle", busy, 0);
        go(3);
        wait_done("t5_drain", 50);

        // reset mid-burst
        for (int i = 0; i < 5; i++) write_word(DW'(8'hC0 + i));
        go(5);
        for (int i = 0; i < 50 && burst_acc < 2; i++) @(negedge clk);
        check("t6_two_accepted", burst_acc, 2);
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_rden", fifo_rden, 0);
        check("t6_rst_valid", m_valid, 0);
        check("t6_rst_data", m_data, 0);
        rc = rd_cnt;
        repeat (3) tick();
        check("t6_no_pops", rd_cnt, rc);
        rst_n = 1'b1;
        tick();
        go(wr_cnt - rd_cnt);
        wait_done("t6_after", 50);

        // randomized bursts
        for (int it = 0; it < 25; it++) begin
            len   = int'($urandom_range(1, 15));
            rmode = int'($urandom_range(0, 2));
            fork
                begin
                    int k;
                    k = 0;
                    while (k < len) begin
                        if ((wr_cnt - rd_cnt) < 8 && $urandom_range(0, 3) != 0) begin
                            write_word(DW'($urandom));
                            k++;
                        end
                        tick();
                    end
                end
                begin
                    go(len);
                    wait_done("rand", 600);
                end
            join
        end
        rmode = 0;
        repeat (3) tick();
        check("all_words_accounted", mon_idx, exp_q.size());

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
